// File: rtl/hci_cpuif_arbiter.sv
// Round-robin arbiter sharing the I3C CSR CPU interface between two requesters.
// One transaction outstanding at a time; a watchdog force-completes accesses the CSR block never acknowledges.
module hci_cpuif_arbiter #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  busy_o,
    output logic                  owner_o,
    output logic                  timeout_o,

    input  logic                  m0_cpuif_req,
    input  logic                  m0_cpuif_req_is_wr,
    input  logic [ADDR_WIDTH-1:0] m0_cpuif_addr,
    input  logic [DATA_WIDTH-1:0] m0_cpuif_wr_data,
    input  logic [DATA_WIDTH-1:0] m0_cpuif_wr_biten,
    output logic                  m0_cpuif_req_stall_wr,
    output logic                  m0_cpuif_req_stall_rd,
    output logic                  m0_cpuif_rd_ack,
    output logic                  m0_cpuif_rd_err,
    output logic [DATA_WIDTH-1:0] m0_cpuif_rd_data,
    output logic                  m0_cpuif_wr_ack,
    output logic                  m0_cpuif_wr_err,

    input  logic                  m1_cpuif_req,
    input  logic                  m1_cpuif_req_is_wr,
    input  logic [ADDR_WIDTH-1:0] m1_cpuif_addr,
    input  logic [DATA_WIDTH-1:0] m1_cpuif_wr_data,
    input  logic [DATA_WIDTH-1:0] m1_cpuif_wr_biten,
    output logic                  m1_cpuif_req_stall_wr,
    output logic                  m1_cpuif_req_stall_rd,
    output logic                  m1_cpuif_rd_ack,
    output logic                  m1_cpuif_rd_err,
    output logic [DATA_WIDTH-1:0] m1_cpuif_rd_data,
    output logic                  m1_cpuif_wr_ack,
    output logic                  m1_cpuif_wr_err,

    output logic                  s_cpuif_req,
    output logic                  s_cpuif_req_is_wr,
    output logic [ADDR_WIDTH-1:0] s_cpuif_addr,
    output logic [DATA_WIDTH-1:0] s_cpuif_wr_data,
    output logic [DATA_WIDTH-1:0] s_cpuif_wr_biten,
    input  logic                  s_cpuif_req_stall_wr,
    input  logic                  s_cpuif_req_stall_rd,
    input  logic                  s_cpuif_rd_ack,
    input  logic                  s_cpuif_rd_err,
    input  logic [DATA_WIDTH-1:0] s_cpuif_rd_data,
    input  logic                  s_cpuif_wr_ack,
    input  logic                  s_cpuif_wr_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BUSY} state_e;

    localparam logic       WD_ON    = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] WD_LIMIT = (TIMEOUT_CYCLES > 255) ? 8'hFF : 8'(TIMEOUT_CYCLES);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic       rr_last_q, rr_last_d;
    logic       is_wr_q, is_wr_d;
    logic       timeout_q, timeout_d;
    logic [7:0] wd_cnt_q, wd_cnt_d;

    logic sel, sel_valid, sel_is_wr, accept, ack_any, wd_fire;
    logic cpl_valid, cpl_idx;
    logic cpl_rd_ack, cpl_rd_err, cpl_wr_ack, cpl_wr_err;
    logic [DATA_WIDTH-1:0] cpl_rd_data;

    // Grant selection: fresh round-robin in IDLE, locked to the stalled owner in WAIT.
    always_comb begin
        sel       = 1'b0;
        sel_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sel       = (m0_cpuif_req && m1_cpuif_req) ? !rr_last_q : m1_cpuif_req;
                sel_valid = m0_cpuif_req | m1_cpuif_req;
            end
            ST_WAIT: begin
                sel       = owner_q;
                sel_valid = owner_q ? m1_cpuif_req : m0_cpuif_req;
            end
            default: sel_valid = 1'b0;
        endcase
        if (rst_i) begin
            sel_valid = 1'b0;
        end
    end

    assign sel_is_wr         = sel ? m1_cpuif_req_is_wr : m0_cpuif_req_is_wr;
    assign s_cpuif_req       = sel_valid;
    assign s_cpuif_req_is_wr = sel_is_wr;
    assign s_cpuif_addr      = sel ? m1_cpuif_addr     : m0_cpuif_addr;
    assign s_cpuif_wr_data   = sel ? m1_cpuif_wr_data  : m0_cpuif_wr_data;
    assign s_cpuif_wr_biten  = sel ? m1_cpuif_wr_biten : m0_cpuif_wr_biten;

    assign accept  = sel_valid & ~(sel_is_wr ? s_cpuif_req_stall_wr : s_cpuif_req_stall_rd);
    assign ack_any = s_cpuif_rd_ack | s_cpuif_wr_ack;
    assign wd_fire = WD_ON && (state_q == ST_BUSY) && (wd_cnt_q == WD_LIMIT) && !ack_any;

    // Completions reach the winner in its accept cycle, or the owner while BUSY; anything else is dropped.
    assign cpl_valid   = accept | (state_q == ST_BUSY);
    assign cpl_idx     = (state_q == ST_BUSY) ? owner_q : sel;
    assign cpl_rd_ack  = s_cpuif_rd_ack | (wd_fire & ~is_wr_q);
    assign cpl_rd_err  = (s_cpuif_rd_ack & s_cpuif_rd_err) | (wd_fire & ~is_wr_q);
    assign cpl_wr_ack  = s_cpuif_wr_ack | (wd_fire & is_wr_q);
    assign cpl_wr_err  = (s_cpuif_wr_ack & s_cpuif_wr_err) | (wd_fire & is_wr_q);
    assign cpl_rd_data = s_cpuif_rd_ack ? s_cpuif_rd_data : '0;

    always_comb begin
        m0_cpuif_req_stall_wr = 1'b1;
        m0_cpuif_req_stall_rd = 1'b1;
        m1_cpuif_req_stall_wr = 1'b1;
        m1_cpuif_req_stall_rd = 1'b1;
        if (sel_valid && !sel) begin
            m0_cpuif_req_stall_wr = s_cpuif_req_stall_wr;
            m0_cpuif_req_stall_rd = s_cpuif_req_stall_rd;
        end
        if (sel_valid && sel) begin
            m1_cpuif_req_stall_wr = s_cpuif_req_stall_wr;
            m1_cpuif_req_stall_rd = s_cpuif_req_stall_rd;
        end
    end

    always_comb begin
        m0_cpuif_rd_ack  = 1'b0;
        m0_cpuif_rd_err  = 1'b0;
        m0_cpuif_rd_data = '0;
        m0_cpuif_wr_ack  = 1'b0;
        m0_cpuif_wr_err  = 1'b0;
        m1_cpuif_rd_ack  = 1'b0;
        m1_cpuif_rd_err  = 1'b0;
        m1_cpuif_rd_data = '0;
        m1_cpuif_wr_ack  = 1'b0;
        m1_cpuif_wr_err  = 1'b0;
        if (cpl_valid && !cpl_idx) begin
            m0_cpuif_rd_ack  = cpl_rd_ack;
            m0_cpuif_rd_err  = cpl_rd_err;
            m0_cpuif_rd_data = cpl_rd_data;
            m0_cpuif_wr_ack  = cpl_wr_ack;
            m0_cpuif_wr_err  = cpl_wr_err;
        end
        if (cpl_valid && cpl_idx) begin
            m1_cpuif_rd_ack  = cpl_rd_ack;
            m1_cpuif_rd_err  = cpl_rd_err;
            m1_cpuif_rd_data = cpl_rd_data;
            m1_cpuif_wr_ack  = cpl_wr_ack;
            m1_cpuif_wr_err  = cpl_wr_err;
        end
    end

    // wd_cnt starts at 1 in the first BUSY cycle so the forced ack lands TIMEOUT_CYCLES after accept.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        is_wr_d   = is_wr_q;
        wd_cnt_d  = wd_cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (accept) begin
                    owner_d   = sel;
                    rr_last_d = sel;
                    is_wr_d   = sel_is_wr;
                    wd_cnt_d  = 8'd1;
                    state_d   = ack_any ? ST_IDLE : ST_BUSY;
                end else if (sel_valid) begin
                    owner_d = sel;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (ack_any) begin
                    state_d = ST_IDLE;
                end else if (wd_fire) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else if (wd_cnt_q != 8'hFF) begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            is_wr_q   <= 1'b0;
            wd_cnt_q  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            is_wr_q   <= is_wr_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy_o    = (state_q == ST_BUSY);
    assign owner_o   = owner_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_hci_cpuif_arbiter.sv
// Bench for hci_cpuif_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_hci_cpuif_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef logic [AW-1:0] addr_t;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    logic [1:0]    rq, wr;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdata [2];
    logic [DW-1:0] biten [2];
    logic [1:0]    o_stall_wr, o_stall_rd, o_rd_ack, o_rd_err, o_wr_ack, o_wr_err;
    logic [DW-1:0] o_rd_data [2];
    logic          s_req, s_is_wr;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_biten, s_rd_data;
    logic          s_stall_wr, s_stall_rd, s_rd_ack, s_rd_err, s_wr_ack, s_wr_err;
    logic          busy_o, owner_o, timeout_o;

    hci_cpuif_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .busy_o(busy_o), .owner_o(owner_o), .timeout_o(timeout_o),
        .m0_cpuif_req(rq[0]), .m0_cpuif_req_is_wr(wr[0]), .m0_cpuif_addr(addr[0]),
        .m0_cpuif_wr_data(wdata[0]), .m0_cpuif_wr_biten(biten[0]),
        .m0_cpuif_req_stall_wr(o_stall_wr[0]), .m0_cpuif_req_stall_rd(o_stall_rd[0]),
        .m0_cpuif_rd_ack(o_rd_ack[0]), .m0_cpuif_rd_err(o_rd_err[0]), .m0_cpuif_rd_data(o_rd_data[0]),
        .m0_cpuif_wr_ack(o_wr_ack[0]), .m0_cpuif_wr_err(o_wr_err[0]),
        .m1_cpuif_req(rq[1]), .m1_cpuif_req_is_wr(wr[1]), .m1_cpuif_addr(addr[1]),
        .m1_cpuif_wr_data(wdata[1]), .m1_cpuif_wr_biten(biten[1]),
        .m1_cpuif_req_stall_wr(o_stall_wr[1]), .m1_cpuif_req_stall_rd(o_stall_rd[1]),
        .m1_cpuif_rd_ack(o_rd_ack[1]), .m1_cpuif_rd_err(o_rd_err[1]), .m1_cpuif_rd_data(o_rd_data[1]),
        .m1_cpuif_wr_ack(o_wr_ack[1]), .m1_cpuif_wr_err(o_wr_err[1]),
        .s_cpuif_req(s_req), .s_cpuif_req_is_wr(s_is_wr), .s_cpuif_addr(s_addr),
        .s_cpuif_wr_data(s_wdata), .s_cpuif_wr_biten(s_biten),
        .s_cpuif_req_stall_wr(s_stall_wr), .s_cpuif_req_stall_rd(s_stall_rd),
        .s_cpuif_rd_ack(s_rd_ack), .s_cpuif_rd_err(s_rd_err), .s_cpuif_rd_data(s_rd_data),
        .s_cpuif_wr_ack(s_wr_ack), .s_cpuif_wr_err(s_wr_err)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who holds the bus, who is locked in, age of the outstanding access.
    bit m_busy, m_own, m_last, m_lock, m_is_wr, m_to;
    int m_age;
    bit g, g_valid, acc, ack_any, fire;
    logic [1:0]    e_stall_wr, e_stall_rd, e_rd_ack, e_rd_err, e_wr_ack, e_wr_err;
    logic [DW-1:0] e_rd_data [2];

    task automatic model_reset();
        m_busy = 0; m_own = 0; m_last = 1; m_lock = 0; m_is_wr = 0; m_to = 0; m_age = 0;
    endtask

    task automatic model_eval();
        bit to_idx;
        ack_any = s_rd_ack || s_wr_ack;
        if (m_busy) begin
            g = m_own; g_valid = 0;
        end else if (m_lock) begin
            g = m_own; g_valid = rq[m_own];
        end else begin
            g = (rq[0] && rq[1]) ? !m_last : rq[1];
            g_valid = rq[0] || rq[1];
        end
        acc  = g_valid && !(wr[g] ? s_stall_wr : s_stall_rd);
        fire = m_busy && (m_age == TO) && !ack_any;
        to_idx = m_busy ? m_own : g;
        e_stall_wr = 2'b11; e_stall_rd = 2'b11;
        e_rd_ack = 0; e_rd_err = 0; e_wr_ack = 0; e_wr_err = 0;
        e_rd_data[0] = '0; e_rd_data[1] = '0;
        if (g_valid) begin
            e_stall_wr[g] = s_stall_wr;
            e_stall_rd[g] = s_stall_rd;
        end
        if (acc || m_busy) begin
            e_rd_ack[to_idx] = s_rd_ack || (fire && !m_is_wr);
            e_rd_err[to_idx] = (s_rd_ack && s_rd_err) || (fire && !m_is_wr);
            e_wr_ack[to_idx] = s_wr_ack || (fire && m_is_wr);
            e_wr_err[to_idx] = (s_wr_ack && s_wr_err) || (fire && m_is_wr);
            e_rd_data[to_idx] = s_rd_ack ? s_rd_data : '0;
        end
    endtask

    task automatic model_update();
        m_to = fire;
        if (m_busy) begin
            if (ack_any || fire) m_busy = 0;
            else if (m_age < 255) m_age++;
        end else if (acc) begin
            m_own = g; m_last = g; m_is_wr = wr[g]; m_lock = 0; m_busy = !ack_any; m_age = 1;
        end else if (g_valid) begin
            m_own = g; m_lock = 1;
        end else begin
            m_lock = 0;
        end
    endtask

    task automatic compare();
        check1("busy_o", busy_o, m_busy);
        check1("owner_o", owner_o, m_own);
        check1("timeout_o", timeout_o, m_to);
        check1("s_req", s_req, g_valid);
        if (g_valid) begin
            check1("s_is_wr", s_is_wr, wr[g]);
            check32("s_addr", 32'(s_addr), 32'(addr[g]));
            check32("s_wdata", s_wdata, wdata[g]);
            check32("s_biten", s_biten, biten[g]);
        end
        for (int n = 0; n < 2; n++) begin
            if (rq[n]) begin
                check1($sformatf("m%0d_stall_wr", n), o_stall_wr[n], e_stall_wr[n]);
                check1($sformatf("m%0d_stall_rd", n), o_stall_rd[n], e_stall_rd[n]);
            end
            check1($sformatf("m%0d_rd_ack", n), o_rd_ack[n], e_rd_ack[n]);
            check1($sformatf("m%0d_rd_err", n), o_rd_err[n], e_rd_err[n]);
            check1($sformatf("m%0d_wr_ack", n), o_wr_ack[n], e_wr_ack[n]);
            check1($sformatf("m%0d_wr_err", n), o_wr_err[n], e_wr_err[n]);
            check32($sformatf("m%0d_rd_data", n), o_rd_data[n], e_rd_data[n]);
        end
    endtask

    // Inputs are set at posedge+1; half() checks at the following negedge; tick() moves to the next posedge+1.
    task automatic half();
        model_eval();
        @(negedge clk);
        compare();
        model_update();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] b);
        rq[n] = 1'b1; wr[n] = w; addr[n] = a; wdata[n] = d; biten[n] = b;
    endtask

    task automatic clear_acks();
        s_rd_ack = 0; s_rd_err = 0; s_wr_ack = 0; s_wr_err = 0; s_rd_data = $urandom;
    endtask

    task automatic drive_ack(input logic w);
        if (w) begin
            s_wr_ack = 1'b1; s_wr_err = ($urandom_range(0, 4) == 0);
        end else begin
            s_rd_ack = 1'b1; s_rd_err = ($urandom_range(0, 4) == 0); s_rd_data = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        rq = 0; wr = 0;
        s_stall_wr = 0; s_stall_rd = 0;
        clear_acks();
        repeat (2) @(posedge clk);
        #1;
        check1("reset busy_o", busy_o, 1'b0);
        check1("reset owner_o", owner_o, 1'b0);
        check1("reset timeout_o", timeout_o, 1'b0);
        check1("reset m0_rd_ack", o_rd_ack[0], 1'b0);
        check1("reset m1_wr_ack", o_wr_ack[1], 1'b0);
        rst_i = 1'b0;
        model_reset();
    endtask

    int csr_due;
    bit csr_dir, acked, drop, drop_n;

    initial begin
        for (int n = 0; n < 2; n++) begin
            addr[n] = '0; wdata[n] = '0; biten[n] = '0;
        end
        do_reset();

        // Single m0 read, CSR acks two cycles after accept.
        set_req(0, 1'b0, 12'h010, 32'h0, 32'h0);
        half();
        check1("t1 s_req", s_req, 1'b1);
        check32("t1 s_addr", 32'(s_addr), 32'h010);
        tick(); rq[0] = 0;
        check1("t1 busy c1", busy_o, 1'b1);
        half(); tick();
        check1("t1 busy c2", busy_o, 1'b1);
        s_rd_ack = 1; s_rd_data = 32'hDEADBEEF;
        half();
        check1("t1 m0_rd_ack", o_rd_ack[0], 1'b1);
        check32("t1 m0_rd_data", o_rd_data[0], 32'hDEADBEEF);
        check1("t1 m1_rd_ack", o_rd_ack[1], 1'b0);
        check32("t1 m1_rd_data", o_rd_data[1], 32'h0);
        tick(); clear_acks();
        check1("t1 busy c3", busy_o, 1'b0);

        // Continuous dual requests alternate starting with m0.
        do_reset();
        set_req(0, 1'b0, 12'h100, 32'h0, 32'h0);
        set_req(1, 1'b0, 12'h200, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            half();
            check32("t2 grant addr", 32'(s_addr), (k % 2 == 0) ? 32'h100 : 32'h200);
            check1("t2 loser stall_wr", o_stall_wr[(k % 2 == 0) ? 1 : 0], 1'b1);
            check1("t2 loser stall_rd", o_stall_rd[(k % 2 == 0) ? 1 : 0], 1'b1);
            tick();
            s_rd_ack = 1; s_rd_data = 32'h5000 + 32'(k);
            half();
            check1("t2 winner rd_ack", o_rd_ack[(k % 2 == 0) ? 0 : 1], 1'b1);
            tick(); clear_acks();
        end
        rq = 0;

        // m1 write stalled three cycles; m0 arriving meanwhile waits its turn.
        set_req(1, 1'b1, 12'h044, 32'hCAFE0001, 32'hFFFFFFFF);
        s_stall_wr = 1;
        half();
        check1("t3 m1 stall_wr c0", o_stall_wr[1], 1'b1);
        tick();
        check1("t3 busy c1", busy_o, 1'b0);
        check1("t3 owner c1", owner_o, 1'b1);
        set_req(0, 1'b0, 12'h088, 32'h0, 32'h0);
        half();
        check1("t3 m0 stall_rd c1", o_stall_rd[0], 1'b1);
        check32("t3 s_addr c1", 32'(s_addr), 32'h044);
        tick();
        half(); tick();
        s_stall_wr = 0;
        half();
        check1("t3 m1 stall_wr c3", o_stall_wr[1], 1'b0);
        check1("t3 s_is_wr c3", s_is_wr, 1'b1);
        tick(); rq[1] = 0;
        check1("t3 busy c4", busy_o, 1'b1);
        s_wr_ack = 1;
        half();
        check1("t3 m1_wr_ack", o_wr_ack[1], 1'b1);
        tick(); clear_acks();
        half();
        check32("t3 m0 served addr", 32'(s_addr), 32'h088);
        check1("t3 m0 stall_rd c5", o_stall_rd[0], 1'b0);
        tick(); rq[0] = 0;
        s_rd_ack = 1; s_rd_data = 32'h0000ABCD;
        half();
        check1("t3 m0_rd_ack", o_rd_ack[0], 1'b1);
        tick(); clear_acks();

        // Same-cycle acks: five m0 reads in five consecutive cycles.
        set_req(0, 1'b0, 12'h020, 32'h0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            s_rd_ack = 1; s_rd_data = 32'h1000 + 32'(k);
            half();
            check1("t4 m0_rd_ack", o_rd_ack[0], 1'b1);
            check32("t4 m0_rd_data", o_rd_data[0], 32'h1000 + 32'(k));
            check1("t4 busy_o", busy_o, 1'b0);
            tick();
        end
        rq[0] = 0; clear_acks();

        // Watchdog on an unacknowledged m1 write; late ack afterwards is dropped.
        set_req(1, 1'b1, 12'h0F0, 32'h12345678, 32'h0000FFFF);
        half(); tick(); rq[1] = 0;
        for (int i = 1; i <= TO; i++) begin
            half();
            check1("t5 m1_wr_ack", o_wr_ack[1], (i == TO));
            check1("t5 m1_wr_err", o_wr_err[1], (i == TO));
            check1("t5 m0_wr_ack", o_wr_ack[0], 1'b0);
            tick();
        end
        check1("t5 timeout pulse", timeout_o, 1'b1);
        check1("t5 busy after", busy_o, 1'b0);
        half(); tick();
        check1("t5 timeout low", timeout_o, 1'b0);
        s_wr_ack = 1;
        half();
        check1("t5 late m1_wr_ack", o_wr_ack[1], 1'b0);
        check1("t5 late m0_wr_ack", o_wr_ack[0], 1'b0);
        tick(); clear_acks();

        // Reset in the middle of BUSY, then the first tie goes to m0.
        set_req(0, 1'b0, 12'h030, 32'h0, 32'h0);
        half(); tick(); rq[0] = 0;
        check1("t6 busy before", busy_o, 1'b1);
        rst_i = 1; s_rd_ack = 1; s_rd_data = 32'hBAD0BAD0;
        #2;
        check1("t6 busy in reset", busy_o, 1'b0);
        check1("t6 m0_rd_ack in reset", o_rd_ack[0], 1'b0);
        check1("t6 m1_rd_ack in reset", o_rd_ack[1], 1'b0);
        clear_acks();
        set_req(0, 1'b0, 12'h100, 32'h0, 32'h0);
        set_req(1, 1'b1, 12'h200, 32'h77, 32'hF);
        tick();
        rst_i = 0;
        model_reset();
        half();
        check32("t6 first tie", 32'(s_addr), 32'h100);
        tick(); rq[0] = 0;

        // Randomized traffic against the model.
        csr_due = 0; csr_dir = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (!rq[n] && $urandom_range(0, 99) < 50)
                    set_req(n, 1'($urandom_range(0, 1)), addr_t'($urandom), $urandom, $urandom);
            end
            s_stall_wr = ($urandom_range(0, 99) < 25);
            s_stall_rd = ($urandom_range(0, 99) < 25);
            clear_acks();
            acked = 0;
            if (csr_due > 0) begin
                csr_due--;
                if (csr_due == 0) begin
                    drive_ack(csr_dir); acked = 1;
                end
            end
            model_eval();
            if (acc && !acked && $urandom_range(0, 99) < 25) begin
                drive_ack(wr[g]); acked = 1;
            end
            if (!acked && $urandom_range(0, 99) < 3) begin
                drive_ack(1'($urandom_range(0, 1)));
            end
            half();
            drop = acc; drop_n = g;
            if (acc && !ack_any) begin
                csr_due = $urandom_range(1, 6); csr_dir = wr[g];
            end
            tick();
            if (drop) rq[drop_n] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
